// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - HI/LO owner and multicycle sequencer for the shared 32x32 multiplier
module mult_hilo_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_product,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    // Counter starts at LATENCY-1 so the write happens LATENCY cycles after acceptance.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] result;

    // Two's-complement magnitudes; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        a_mag  = a[31] ? (~a + 32'd1) : a;
        b_mag  = b[31] ? (~b + 32'd1) : b;
        result = neg ? (~mul_product + 64'd1) : mul_product;
    end

    // Sequencer: operand capture, settle countdown, sign correction and HI/LO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            neg   <= 1'b0;
            mul_a <= 32'd0;
            mul_b <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULTU: begin
                                mul_a <= a;
                                mul_b <= b;
                                neg   <= 1'b0;
                                cnt   <= CNT_INIT;
                                busy  <= 1'b1;
                                state <= CALC;
                            end
                            OP_MULT: begin
                                mul_a <= a_mag;
                                mul_b <= b_mag;
                                neg   <= a[31] ^ b[31];
                                cnt   <= CNT_INIT;
                                busy  <= 1'b1;
                                state <= CALC;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        hi    <= result[63:32];
                        lo    <= result[31:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - directed self-checking bench for mult_hilo_ctrl
module tb_mult_hilo_ctrl;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] MTHI  = 2'b10;
    localparam logic [1:0] MTLO  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // LATENCY=4 instance
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_product;
    logic        busy, done;
    logic [31:0] hi, lo;

    // LATENCY=1 instance
    logic        start1 = 1'b0;
    logic [1:0]  op1 = 2'b00;
    logic [31:0] a1 = 32'd0;
    logic [31:0] b1 = 32'd0;
    logic        flush1 = 1'b0;
    logic [31:0] mul_a1, mul_b1;
    logic [63:0] mul_product1;
    logic        busy1, done1;
    logic [31:0] hi1, lo1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External combinational multipliers
    assign mul_product  = {32'd0, mul_a}  * {32'd0, mul_b};
    assign mul_product1 = {32'd0, mul_a1} * {32'd0, mul_b1};

    mult_hilo_ctrl #(.LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mult_hilo_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1), .flush(flush1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_product(mul_product1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a multiply at a negedge; returns at the negedge of the done cycle.
    task automatic do_mul(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp_r);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, {63'd0, busy}, 64'd1);
            check({tag, " done early"}, {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        check({tag, " busy end"}, {63'd0, busy}, 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hilo"}, {hi, lo}, exp_r);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst hilo", {hi, lo}, 64'd0);
        check("rst mul", {mul_a, mul_b}, 64'd0);
        check("rst busy/done", {62'd0, busy, done}, 64'd0);
        check("rst1 hilo", {hi1, lo1}, 64'd0);
        check("rst1 busy/done", {62'd0, busy1, done1}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_mul("multu ff", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("done pulse width", {63'd0, done}, 64'd0);
        do_mul("mult 7x-3", MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        do_mul("mult -1x-1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        @(negedge clk);
        do_mul("mult min", MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        @(negedge clk);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = MTHI; a = 32'h1234_5678;
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        check("mthi done", {62'd0, busy, done}, 64'd0);
        op = MTLO; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo done", {62'd0, busy, done}, 64'd0);

        // Flush in the second CALC cycle
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("flush no done", {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        check("flush hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Flush coincident with the cnt=0 write edge
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush last busy/done", {62'd0, busy, done}, 64'd0);
        check("flush last hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Flush in IDLE beats start
        start = 1'b1; op = MTHI; a = 32'h0BAD_0BAD; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle flush hi", {32'd0, hi}, {32'd0, 32'h1234_5678});

        do_mul("mult 0x-1", MULT, 32'd0, 32'hFFFF_FFFF, 64'd0);
        @(negedge clk);

        // MTLO presented while CALC is in progress
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        @(negedge clk);
        op = MTLO; a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mtlo in calc", {32'd0, lo}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("3x5 done", {63'd0, done}, 64'd1);
        check("3x5 hilo", {hi, lo}, 64'd15);
        @(negedge clk);
        check("3x5 hold", {hi, lo}, 64'd15);

        // Back-to-back: second start in the done cycle
        do_mul("b2b first", MULTU, 32'd2, 32'd3, 64'd6);
        do_mul("b2b second", MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        @(negedge clk);
        check("b2b done drop", {63'd0, done}, 64'd0);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = MULT; a = 32'd7; b = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst hilo", {hi, lo}, 64'd0);
        check("arst mul", {mul_a, mul_b}, 64'd0);
        check("arst busy/done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post arst idle", {62'd0, busy, done}, 64'd0);
        end
        check("post arst hilo", {hi, lo}, 64'd0);

        // LATENCY=1 instance: done in cycle E+2
        start1 = 1'b1; op1 = MULT; a1 = 32'd7; b1 = 32'hFFFF_FFFD;
        @(negedge clk);
        start1 = 1'b0;
        check("l1 busy", {62'd0, busy1, done1}, 64'd2);
        @(negedge clk);
        check("l1 done", {62'd0, busy1, done1}, 64'd1);
        check("l1 hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check("l1 done drop", {63'd0, done1}, 64'd0);

        // LATENCY=1 asynchronous reset mid-CALC
        start1 = 1'b1; op1 = MULTU; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
        @(negedge clk);
        start1 = 1'b0;
        check("l1 arst busy before", {63'd0, busy1}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("l1 arst hilo", {hi1, lo1}, 64'd0);
        check("l1 arst mul", {mul_a1, mul_b1}, 64'd0);
        check("l1 arst busy/done", {62'd0, busy1, done1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("l1 post arst", {62'd0, busy1, done1}, 64'd0);
        end
        check("l1 post arst hilo", {hi1, lo1}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
